// File: rtl/data_mem_responder.sv
// Data-memory responder: single-outstanding load/store port with a programmable
// fixed service latency, RISC-V load extension, byte-lane stores and misalignment errors.
module data_mem_responder #(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32,
  parameter int LATENCY    = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [DM_ADDRESS-1:0] req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  input  logic [2:0]            req_funct3,
  output logic                  rsp_valid,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic                  rsp_err,
  output logic                  busy
);

  localparam int DEPTH = 1 << (DM_ADDRESS - 2);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t                r_state;
  logic [3:0]            r_cnt;
  logic                  r_we;
  logic [DM_ADDRESS-1:0] r_addr;
  logic [DATA_W-1:0]     r_wdata;
  logic [2:0]            r_funct3;
  logic                  r_err;
  logic [DATA_W-1:0]     r_mem [DEPTH];

  logic                  w_accept;
  logic                  w_illegal;
  logic                  w_enter_resp;
  logic                  w_cur_we;
  logic                  w_cur_err;
  logic [DM_ADDRESS-1:0] w_cur_addr;
  logic [2:0]            w_cur_funct3;
  logic [DATA_W-1:0]     w_rword;
  logic [7:0]            w_byte;
  logic [15:0]           w_half;
  logic [DATA_W-1:0]     w_load;
  logic [DATA_W-1:0]     w_wword;
  logic [3:0]            w_wmask;

  assign req_ready = (r_state == IDLE) && !reset;
  assign busy      = (r_state != IDLE);
  assign w_accept  = req_valid && req_ready;

  // With LATENCY 1 the RESP entry edge is the accept edge, so read from the live request.
  assign w_cur_we     = (r_state == IDLE) ? req_we     : r_we;
  assign w_cur_addr   = (r_state == IDLE) ? req_addr   : r_addr;
  assign w_cur_funct3 = (r_state == IDLE) ? req_funct3 : r_funct3;
  assign w_cur_err    = (r_state == IDLE) ? w_illegal  : r_err;

  assign w_enter_resp = ((r_state == IDLE) && w_accept && (LATENCY == 1)) ||
                        ((r_state == WAIT) && (r_cnt == 4'd0));

  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    w_illegal = 1'b1;
    case (req_funct3)
      3'b000:  w_illegal = 1'b0;
      3'b100:  w_illegal = req_we;
      3'b001:  w_illegal = req_addr[0];
      3'b101:  w_illegal = req_we || req_addr[0];
      3'b010:  w_illegal = |req_addr[1:0];
      default: w_illegal = 1'b1;
    endcase
  end

  assign w_rword = r_mem[w_cur_addr[DM_ADDRESS-1:2]];

  always_comb begin
    w_byte = w_rword[{w_cur_addr[1:0], 3'b000} +: 8];
    w_half = w_cur_addr[1] ? w_rword[31:16] : w_rword[15:0];
    w_load = '0;
    case (w_cur_funct3)
      3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
      3'b100:  w_load = {24'd0, w_byte};
      3'b001:  w_load = {{16{w_half[15]}}, w_half};
      3'b101:  w_load = {16'd0, w_half};
      3'b010:  w_load = w_rword;
      default: w_load = '0;
    endcase
  end

  // Store data is replicated across lanes; the mask picks which lanes commit.
  always_comb begin
    w_wword = r_wdata;
    w_wmask = 4'b0000;
    case (r_funct3[1:0])
      2'b00: begin
        w_wword = {4{r_wdata[7:0]}};
        w_wmask = 4'b0001 << r_addr[1:0];
      end
      2'b01: begin
        w_wword = {2{r_wdata[15:0]}};
        w_wmask = r_addr[1] ? 4'b1100 : 4'b0011;
      end
      2'b10:   w_wmask = 4'b1111;
      default: w_wmask = 4'b0000;
    endcase
  end

  // NOTE: storage is deliberately left out of reset; only control state is cleared.
  always_ff @(posedge clk) begin
    if (!reset && (r_state == RESP) && r_we && !r_err) begin
      for (int i = 0; i < 4; i++) begin
        if (w_wmask[i]) r_mem[r_addr[DM_ADDRESS-1:2]][8*i +: 8] <= w_wword[8*i +: 8];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_cnt     <= 4'd0;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_funct3  <= 3'b000;
      r_err     <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      if (w_enter_resp) begin
        rsp_valid <= 1'b1;
        rsp_err   <= w_cur_err;
        rsp_rdata <= (w_cur_we || w_cur_err) ? '0 : w_load;
      end
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_we     <= req_we;
            r_addr   <= req_addr;
            r_wdata  <= req_wdata;
            r_funct3 <= req_funct3;
            r_err    <= w_illegal;
            if (LATENCY == 1) begin
              r_state <= RESP;
            end else begin
              r_cnt   <= 4'(LATENCY - 2);
              r_state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (r_cnt == 4'd0) r_state <= RESP;
          else               r_cnt   <= r_cnt - 4'd1;
        end
        RESP:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: a LATENCY=2 instance for functional and
// random traffic plus a LATENCY=1 instance for back-to-back throughput.
module tb_data_mem_responder;

  localparam int LAT0 = 2;
  localparam int LAT1 = 1;

  typedef struct {
    logic [31:0] rd;
    logic        err;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst    [2];
  logic        valid  [2];
  logic        we     [2];
  logic [8:0]  addr   [2];
  logic [31:0] wdata  [2];
  logic [2:0]  f3     [2];
  logic        rdy    [2];
  logic        rv     [2];
  logic [31:0] rd     [2];
  logic        err    [2];
  logic        busy   [2];
  logic        rst_q  [2];
  logic [31:0] held_rd  [2];
  logic        held_err [2];

  logic [7:0]  mem [2][512];
  exp_t        q0[$];
  exp_t        q1[$];
  int          last_acc [2];
  int          cyc = 0;
  int          n_checks = 0;
  int          n_pass = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) for (int i = 0; i < 2; i++) rst_q[i] <= rst[i];

  data_mem_responder #(.DM_ADDRESS(9), .DATA_W(32), .LATENCY(LAT0)) u_dut0 (
    .clk(clk), .reset(rst[0]), .req_valid(valid[0]), .req_ready(rdy[0]),
    .req_we(we[0]), .req_addr(addr[0]), .req_wdata(wdata[0]), .req_funct3(f3[0]),
    .rsp_valid(rv[0]), .rsp_rdata(rd[0]), .rsp_err(err[0]), .busy(busy[0])
  );

  data_mem_responder #(.DM_ADDRESS(9), .DATA_W(32), .LATENCY(LAT1)) u_dut1 (
    .clk(clk), .reset(rst[1]), .req_valid(valid[1]), .req_ready(rdy[1]),
    .req_we(we[1]), .req_addr(addr[1]), .req_wdata(wdata[1]), .req_funct3(f3[1]),
    .rsp_valid(rv[1]), .rsp_rdata(rd[1]), .rsp_err(err[1]), .busy(busy[1])
  );

  task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic int lat(input int id);
    return (id == 0) ? LAT0 : LAT1;
  endfunction

  // Byte-addressed reference: size/sign from funct3, alignment by modulo, little-endian assembly.
  function automatic void model(input int id, input logic w, input logic [8:0] a, input logic [31:0] wd,
                                input logic [2:0] fn, output logic [31:0] rdo, output logic ero);
    int     sz;
    bit     sgn;
    longint v;
    sz = 0; sgn = 0; v = 0; rdo = '0;
    case (fn)
      3'd0:    begin sz = 1; sgn = 1; end
      3'd1:    begin sz = 2; sgn = 1; end
      3'd2:    sz = 4;
      3'd4:    sz = 1;
      3'd5:    sz = 2;
      default: sz = 0;
    endcase
    ero = (sz == 0) || (w && fn[2]) || ((int'(a) % ((sz == 0) ? 1 : sz)) != 0);
    if (ero) return;
    for (int i = 0; i < sz; i++) begin
      if (w) mem[id][int'(a) + i] = wd[8*i +: 8];
      else   v = v | (longint'(mem[id][int'(a) + i]) << (8 * i));
    end
    if (!w && sgn && v[8*sz-1]) v = v - (longint'(1) << (8 * sz));
    if (!w) rdo = v[31:0];
  endfunction

  task automatic issue(input int id, input logic w, input logic [8:0] a, input logic [31:0] wd,
                       input logic [2:0] fn, input bit hold, input bit ovr,
                       input logic [31:0] ovr_rd, input logic ovr_err);
    exp_t        e;
    int          n;
    logic [31:0] mrd;
    logic        merr;
    @(negedge clk);
    we[id] = w; addr[id] = a; wdata[id] = wd; f3[id] = fn; valid[id] = 1'b1;
    n = 0;
    while (!rdy[id] && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!rdy[id]) begin
      check(1'b0, "accept_timeout", 32'(n), 32'd40);
      valid[id] = 1'b0;
      last_acc[id] = -1;
      return;
    end
    if (last_acc[id] >= 0)
      check(cyc == last_acc[id] + lat(id) + 1, "accept_spacing", 32'(cyc), 32'(last_acc[id] + lat(id) + 1));
    last_acc[id] = cyc;
    model(id, w, a, wd, fn, mrd, merr);
    e.rd  = ovr ? ovr_rd  : mrd;
    e.err = ovr ? ovr_err : merr;
    e.cyc = cyc + lat(id);
    if (id == 0) q0.push_back(e);
    else         q1.push_back(e);
    @(posedge clk);
    #1;
    if (!hold) valid[id] = 1'b0;
  endtask

  task automatic req(input int id, input logic w, input logic [8:0] a, input logic [31:0] wd, input logic [2:0] fn);
    issue(id, w, a, wd, fn, 1'b0, 1'b0, 32'd0, 1'b0);
  endtask

  task automatic req_exp(input logic w, input logic [8:0] a, input logic [31:0] wd, input logic [2:0] fn,
                         input logic [31:0] xrd, input logic xerr);
    issue(0, w, a, wd, fn, 1'b0, 1'b1, xrd, xerr);
  endtask

  // Monitor: pops the scoreboard on every response and checks reset, hold and busy/ready rules.
  always @(negedge clk) begin
    exp_t e;
    bit   have;
    #2;
    for (int id = 0; id < 2; id++) begin
      if (rst_q[id]) begin
        check(!rv[id], $sformatf("rsp_valid_reset%0d", id), 32'(rv[id]), 32'd0);
        check(rd[id] == 32'd0, $sformatf("rsp_rdata_reset%0d", id), rd[id], 32'd0);
        check(!err[id], $sformatf("rsp_err_reset%0d", id), 32'(err[id]), 32'd0);
        held_rd[id]  = 32'd0;
        held_err[id] = 1'b0;
      end else if (rv[id]) begin
        have = (id == 0) ? (q0.size() > 0) : (q1.size() > 0);
        if (!have) begin
          check(1'b0, $sformatf("unexpected_rsp%0d", id), rd[id], 32'd0);
        end else begin
          if (id == 0) e = q0.pop_front();
          else         e = q1.pop_front();
          check(rd[id] == e.rd, $sformatf("rsp_rdata%0d", id), rd[id], e.rd);
          check(err[id] == e.err, $sformatf("rsp_err%0d", id), 32'(err[id]), 32'(e.err));
          check(cyc == e.cyc, $sformatf("rsp_cycle%0d", id), 32'(cyc), 32'(e.cyc));
          held_rd[id]  = e.rd;
          held_err[id] = e.err;
        end
      end else begin
        check(rd[id] == held_rd[id], $sformatf("rdata_hold%0d", id), rd[id], held_rd[id]);
        check(err[id] == held_err[id], $sformatf("err_hold%0d", id), 32'(err[id]), 32'(held_err[id]));
      end
      if (rst[id]) check(!rdy[id], $sformatf("ready_in_reset%0d", id), 32'(rdy[id]), 32'd0);
      else         check(busy[id] != rdy[id], $sformatf("busy_ready%0d", id), 32'(busy[id]), 32'(!rdy[id]));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    for (int i = 0; i < 2; i++) begin
      rst[i] = 1'b1; valid[i] = 1'b0; we[i] = 1'b0; addr[i] = '0;
      wdata[i] = '0; f3[i] = '0; last_acc[i] = -1;
      held_rd[i] = '0; held_err[i] = 1'b0;
    end
    repeat (3) @(negedge clk);
    rst[0] = 1'b0; rst[1] = 1'b0;
    #1;
    check(rdy[0], "ready_after_reset0", 32'(rdy[0]), 32'd1);
    check(rdy[1], "ready_after_reset1", 32'(rdy[1]), 32'd1);

    // Fill all of DUT0 storage so every later load has a defined value.
    for (int w = 0; w < 128; w++) req(0, 1'b1, 9'(w * 4), $urandom, 3'b010);
    req_exp(1'b1, 9'h020, 32'h0000_0000, 3'b010, 32'd0, 1'b0);

    req_exp(1'b1, 9'h010, 32'h8081_F0F2, 3'b010, 32'd0, 1'b0);
    req_exp(1'b0, 9'h010, 32'd0, 3'b010, 32'h8081_F0F2, 1'b0);
    req_exp(1'b0, 9'h013, 32'd0, 3'b000, 32'hFFFF_FF80, 1'b0);
    req_exp(1'b0, 9'h013, 32'd0, 3'b100, 32'h0000_0080, 1'b0);
    req_exp(1'b0, 9'h012, 32'd0, 3'b001, 32'hFFFF_8081, 1'b0);
    req_exp(1'b0, 9'h010, 32'd0, 3'b101, 32'h0000_F0F2, 1'b0);
    req_exp(1'b1, 9'h011, 32'h0000_00AA, 3'b000, 32'd0, 1'b0);
    req_exp(1'b0, 9'h010, 32'd0, 3'b010, 32'h8081_AAF2, 1'b0);
    req_exp(1'b0, 9'h003, 32'd0, 3'b001, 32'd0, 1'b1);
    req_exp(1'b0, 9'h010, 32'd0, 3'b010, 32'h8081_AAF2, 1'b0);
    req_exp(1'b1, 9'h012, 32'hDEAD_BEEF, 3'b010, 32'd0, 1'b1);
    req_exp(1'b0, 9'h010, 32'd0, 3'b010, 32'h8081_AAF2, 1'b0);
    req_exp(1'b0, 9'h010, 32'd0, 3'b011, 32'd0, 1'b1);
    req_exp(1'b0, 9'h010, 32'd0, 3'b010, 32'h8081_AAF2, 1'b0);

    // Reset lands in the WAIT cycle of a store: it must vanish without a response or write.
    @(negedge clk);
    we[0] = 1'b1; addr[0] = 9'h020; wdata[0] = 32'h1234_5678; f3[0] = 3'b010; valid[0] = 1'b1;
    n = 0;
    while (!rdy[0] && n < 40) begin
      @(negedge clk);
      n++;
    end
    check(rdy[0], "reset_test_accept", 32'(rdy[0]), 32'd1);
    @(posedge clk);
    #1 valid[0] = 1'b0;
    @(negedge clk);
    check(busy[0], "busy_in_wait", 32'(busy[0]), 32'd1);
    rst[0] = 1'b1;
    @(negedge clk);
    rst[0] = 1'b0;
    #1;
    check(rdy[0], "ready_after_pulse", 32'(rdy[0]), 32'd1);
    check(!busy[0], "idle_after_pulse", 32'(busy[0]), 32'd0);
    repeat (4) @(negedge clk);
    last_acc[0] = -1;
    req_exp(1'b0, 9'h020, 32'd0, 3'b010, 32'h0000_0000, 1'b0);

    // Random traffic against the byte-level model, including misaligned and illegal forms.
    for (int k = 0; k < 250; k++) begin
      logic [8:0] a;
      a = 9'($urandom_range(0, 511));
      if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
      req(0, 1'($urandom_range(0, 1)), a, $urandom, 3'($urandom_range(0, 7)));
    end

    // LATENCY=1 with req_valid held: accepts every other cycle, responses one cycle later.
    for (int w = 0; w < 4; w++) issue(1, 1'b1, 9'(w * 4), $urandom, 3'b010, 1'b1, 1'b0, 32'd0, 1'b0);
    issue(1, 1'b0, 9'h001, 32'd0, 3'b000, 1'b1, 1'b0, 32'd0, 1'b0);
    issue(1, 1'b0, 9'h006, 32'd0, 3'b101, 1'b1, 1'b0, 32'd0, 1'b0);
    issue(1, 1'b0, 9'h008, 32'd0, 3'b010, 1'b1, 1'b0, 32'd0, 1'b0);
    issue(1, 1'b0, 9'h00F, 32'd0, 3'b100, 1'b1, 1'b0, 32'd0, 1'b0);
    valid[1] = 1'b0;

    repeat (10) @(negedge clk);
    check(q0.size() == 0, "pending_rsp0", 32'(q0.size()), 32'd0);
    check(q1.size() == 0, "pending_rsp1", 32'(q1.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Responder end of the pipeline's data-memory port: accepts one load/store request at a time over a valid/ready handshake, services it after a fixed programmable latency, and returns a single-cycle response. Loads are byte-, half- and word-sized with RISC-V sign/zero extension per funct3. Stores are byte-lane masked. Misaligned or illegal accesses are flagged and never touch storage. The block sits behind the core's MEM stage and replaces the zero-wait data memory when wait-state behaviour must be modelled.

## Interface

Parameters:
- DM_ADDRESS, 9, byte-address width; storage depth is 2^(DM_ADDRESS-2) words.
- DATA_W, 32, data width (fixed at 32; other values unsupported).
- LATENCY, 2, cycles from acceptance to response; legal range 1..15.

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request this cycle
- req_we  in  1  1 = store, 0 = load
- req_addr  in  DM_ADDRESS  byte address
- req_wdata  in  DATA_W  store data; low bits used for SB/SH
- req_funct3  in  3  RISC-V funct3 of the load/store
- rsp_valid  out  1  one-cycle response strobe
- rsp_rdata  out  DATA_W  extended load data; 0 for stores and errors
- rsp_err  out  1  misaligned or illegal funct3; valid with rsp_valid
- busy  out  1  request in flight (state != IDLE)

## Operation

- FSM states: IDLE, WAIT, RESP.
- req_ready = (state == IDLE) && !reset. A transfer is accepted when req_valid && req_ready; we, addr, wdata and funct3 are latched on that edge.
- Acceptance transitions:
  - LATENCY = 1: go to RESP.
  - LATENCY > 1: load the down-counter with LATENCY-2 and go to WAIT.
- WAIT: decrement the counter each cycle; when the counter is 0, go to RESP.
- RESP: rsp_valid = 1 for exactly one cycle, then return to IDLE. rsp has no back-pressure.
- Legality check, computed at acceptance:
  - funct3 000/100 (LB/LBU, SB): any address.
  - funct3 001/101 (LH/LHU, SH): addr[0] must be 0.
  - funct3 010 (LW/SW): addr[1:0] must be 00.
  - Store with funct3 100/101: illegal.
  - funct3 011/110/111: illegal.
  - Any violation sets rsp_err = 1 with rsp_rdata = 0, and no write occurs.
- Word index is addr[DM_ADDRESS-1:2]. Byte lanes are little-endian; lane select is addr[1:0] (byte) or addr[1] (half).
- Loads read the word on the edge entering RESP:
  - LB: sign-extend the selected byte.
  - LBU: zero-extend the selected byte.
  - LH: sign-extend the selected half.
  - LHU: zero-extend the selected half.
  - LW: whole word.
- Stores commit on the edge that ends the RESP cycle. SB writes 1 lane from wdata[7:0], SH writes 2 lanes from wdata[15:0], SW writes 4 lanes. Unselected lanes are preserved.
- Storage contents are not cleared by reset.

## Timing

- Reset values: rsp_valid 0, rsp_rdata 0, rsp_err 0, busy 0, state IDLE, counter 0. req_ready is 0 while reset is high and 1 in the first cycle after reset.
- Accept in cycle t leads to rsp_valid high in cycle t+LATENCY. req_ready is low from t+1 through t+LATENCY and high again in t+LATENCY+1.
- Throughput: one request per LATENCY+1 cycles with req_valid held high.
- A request held while req_ready is low is not lost; it is accepted in the first cycle req_ready is high. Inputs must be held stable until then.
- A store followed by a load to the same word: the load, accepted at or after t+LATENCY+1, returns the new data.
- Reset during WAIT or RESP: the request is dropped, no write occurs, and rsp_valid is 0 from the next cycle. The FSM returns to IDLE.
- rsp_rdata and rsp_err are registered and hold their value after rsp_valid falls until the next response.

## Test plan

- LATENCY=2. SW addr 0x010, wdata 0x8081_F0F2, accepted cycle 5 -> rsp_valid in cycle 7, err 0. Then LW 0x010 accepted cycle 8 -> rsp_rdata 0x8081_F0F2 in cycle 10.
- Loads from that word:
  - LB 0x013 -> 0xFFFF_FF80.
  - LBU 0x013 -> 0x0000_0080.
  - LH 0x012 -> 0xFFFF_8081.
  - LHU 0x010 -> 0x0000_F0F2.
- SB 0x011 wdata 0x0000_00AA, then LW 0x010 -> 0x8081_AAF2.
- Errors, each with rsp_err 1, rsp_rdata 0, and a following LW 0x010 showing memory unchanged:
  - LH at 0x003.
  - SW at 0x012.
  - funct3 011.
- Reset pulsed in the WAIT cycle of SW 0x020 wdata 0x1234_5678 -> no rsp_valid, req_ready 1 one cycle after reset, and a subsequent LW 0x020 does not return 0x1234_5678 (pre-initialise 0x020 to 0).
- LATENCY=1 with req_valid held for 4 loads -> responses in cycles t+1, t+3, t+5, t+7. busy and req_ready are complementary every non-reset cycle.
